// File: rtl/nios_system_mutex_lock_sequencer_if.sv
// rtl/nios_system_mutex_lock_sequencer_if.sv - requester and mutex-slave signals of the lock sequencer
interface nios_system_mutex_lock_sequencer_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic [15:0]        fail_cnt;
  logic               m_address;
  logic               m_chipselect;
  logic               m_write;
  logic               m_read;
  logic [31:0]        m_writedata;
  logic [31:0]        m_readdata;

  modport master (
    input  req, m_readdata,
    output grant, busy, fail_cnt, m_address, m_chipselect, m_write, m_read, m_writedata
  );

  modport slave (
    output req, m_readdata,
    input  grant, busy, fail_cnt, m_address, m_chipselect, m_write, m_read, m_writedata
  );
endinterface

// File: rtl/nios_system_mutex_lock_sequencer.sv
// rtl/nios_system_mutex_lock_sequencer.sv - round-robin hardware front-end for the shared mutex slave
module nios_system_mutex_lock_sequencer #(
  parameter int          NUM_REQ     = 4,
  parameter logic [15:0] OWNER_BASE  = 16'h0100,
  parameter int          RETRY_DELAY = 8
) (
  input  logic                               clk,
  input  logic                               reset_n,
  nios_system_mutex_lock_sequencer_if.master bus
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW    = SEL_W + 1;
  localparam int CNT_W = (RETRY_DELAY > 1) ? $clog2(RETRY_DELAY) : 1;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WR_LOCK   = 3'd1;
  localparam logic [2:0] ST_RD_CHECK  = 3'd2;
  localparam logic [2:0] ST_BACKOFF   = 3'd3;
  localparam logic [2:0] ST_GRANTED   = 3'd4;
  localparam logic [2:0] ST_WR_UNLOCK = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d, rr_q, rr_d, arb_sel, sel_inc;
  logic [IW-1:0]      arb_idx;
  logic               arb_found;
  logic [CNT_W-1:0]   bo_q, bo_d;
  logic [15:0]        fail_cnt_q, fail_cnt_d;
  logic [15:0]        owner_cur, owner_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [31:0]        wdata_d;
  logic               write_d, read_d;

  assign owner_cur     = OWNER_BASE + 16'(sel_q);
  assign sel_inc       = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.m_address = 1'b0;

  // Round-robin search upward from rr_q, wrapping at NUM_REQ (which need not be a power of two).
  always_comb begin
    arb_sel   = rr_q;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_idx = {1'b0, rr_q} + IW'(i);
      if (arb_idx >= IW'(NUM_REQ)) arb_idx = arb_idx - IW'(NUM_REQ);
      if (!arb_found && bus.req[arb_idx[SEL_W-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx[SEL_W-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    rr_d       = rr_q;
    bo_d       = bo_q;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          sel_d   = arb_sel;
          state_d = ST_WR_LOCK;
        end
      end
      ST_WR_LOCK: state_d = ST_RD_CHECK;
      ST_RD_CHECK: begin
        if (bus.m_readdata == {owner_cur, 16'h0001}) begin
          state_d = bus.req[sel_q] ? ST_GRANTED : ST_WR_UNLOCK;
        end else begin
          if (fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
          bo_d    = CNT_W'(RETRY_DELAY - 1);
          state_d = ST_BACKOFF;
        end
      end
      ST_BACKOFF: begin
        if (bo_q == '0) begin
          rr_d    = sel_inc;
          state_d = ST_IDLE;
        end else begin
          bo_d = bo_q - 1'b1;
        end
      end
      ST_GRANTED: begin
        if (!bus.req[sel_q]) state_d = ST_WR_UNLOCK;
      end
      ST_WR_UNLOCK: begin
        rr_d    = sel_inc;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and grant outputs are decoded from the next state so they come straight out of flops.
  always_comb begin
    owner_d = OWNER_BASE + 16'(sel_d);
    grant_d = '0;
    wdata_d = '0;
    write_d = 1'b0;
    read_d  = 1'b0;
    case (state_d)
      ST_WR_LOCK: begin
        write_d = 1'b1;
        wdata_d = {owner_d, 16'h0001};
      end
      ST_RD_CHECK:  read_d = 1'b1;
      ST_WR_UNLOCK: begin
        write_d = 1'b1;
        wdata_d = {owner_d, 16'h0000};
      end
      ST_GRANTED:   grant_d[sel_d] = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= ST_IDLE;
      sel_q            <= '0;
      rr_q             <= '0;
      bo_q             <= '0;
      fail_cnt_q       <= '0;
      bus.grant        <= '0;
      bus.busy         <= 1'b0;
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_read       <= 1'b0;
      bus.m_writedata  <= '0;
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      rr_q             <= rr_d;
      bo_q             <= bo_d;
      fail_cnt_q       <= fail_cnt_d;
      bus.grant        <= grant_d;
      bus.busy         <= (state_d != ST_IDLE);
      bus.m_chipselect <= write_d | read_d;
      bus.m_write      <= write_d;
      bus.m_read       <= read_d;
      bus.m_writedata  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_nios_system_mutex_lock_sequencer.sv
// tb/tb_nios_system_mutex_lock_sequencer.sv - scoreboard bench for the mutex lock sequencer
module tb_nios_system_mutex_lock_sequencer;
  localparam int NUM_REQ     = 4;
  localparam int RETRY_DELAY = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  nios_system_mutex_lock_sequencer_if #(.NUM_REQ(NUM_REQ)) bus ();

  nios_system_mutex_lock_sequencer #(
    .NUM_REQ(NUM_REQ), .OWNER_BASE(16'h0100), .RETRY_DELAY(RETRY_DELAY)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Mutex slave model: a write takes effect when the mutex is free or the owner matches.
  logic [31:0] mutex_q = '0;
  logic        sw_set = 1'b0;
  logic [31:0] sw_val = '0;
  always @(posedge clk) begin
    if (sw_set)
      mutex_q <= sw_val;
    else if (bus.m_chipselect && bus.m_write && !bus.m_address &&
             (mutex_q[15:0] == 16'h0 || mutex_q[31:16] == bus.m_writedata[31:16]))
      mutex_q <= bus.m_writedata;
  end
  assign bus.m_readdata = mutex_q;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  int                 cyc = 0;
  logic [31:0]        wr_q[$];
  logic [NUM_REQ-1:0] gnt_q[$];
  logic [NUM_REQ-1:0] prev_grant = '0;
  logic [31:0]        exp_wd;
  logic [NUM_REQ-1:0] exp_g;
  int last_wr_cyc = 0, wr_gap = 0, unlock_cyc = 0, grant_rise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.m_write) begin
      wr_gap      = cyc - last_wr_cyc;
      last_wr_cyc = cyc;
      if (bus.m_writedata[15:0] == 16'h0) unlock_cyc = cyc;
      exp_wd = (wr_q.size() != 0) ? wr_q.pop_front() : 32'hDEAD_BEEF;
      check("bus_write", bus.m_writedata, exp_wd);
    end
    if (bus.m_write || bus.m_read || bus.m_chipselect)
      check("bus_strobes", 32'({bus.m_chipselect, bus.m_write & bus.m_read, bus.m_address}), 32'b100);
    if (bus.grant != prev_grant) begin
      if (bus.grant != '0) grant_rise_cyc = cyc;
      exp_g = (gnt_q.size() != 0) ? gnt_q.pop_front() : '1;
      check("grant_seq", 32'(bus.grant), 32'(exp_g));
      prev_grant = bus.grant;
    end
  end

  task automatic wait_grant(input string tag, input int budget);
    int n = 0;
    while (bus.grant == '0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, 32'(bus.grant != '0), 1);
  endtask

  task automatic wait_queue(input int level, input int budget);
    int n = 0;
    while (wr_q.size() > level && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("write_drain", 32'(wr_q.size() <= level), 1);
  endtask

  task automatic sw_write(input logic [31:0] val);
    sw_val = val;
    sw_set = 1'b1;
    @(negedge clk);
    sw_set = 1'b0;
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.req = '0;
    sw_val  = '0;
    sw_set  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 32'({bus.grant, bus.busy, bus.fail_cnt, bus.m_address,
                           bus.m_chipselect, bus.m_write, bus.m_read}), 0);
    check("rst_wdata", bus.m_writedata, 0);
    reset_n = 1'b1;
    sw_set  = 1'b0;
    @(negedge clk);

    // Single request on a free mutex.
    wr_q.push_back(32'h0100_0001); wr_q.push_back(32'h0100_0000);
    gnt_q.push_back(4'b0001);      gnt_q.push_back(4'b0000);
    bus.req = 4'b0001;
    repeat (2) @(negedge clk); #1;
    check("single_read_cycle2", 32'(bus.m_read), 1);
    check("single_no_early_grant", 32'(bus.grant), 0);
    @(negedge clk); #1;
    check("single_grant_cycle3", 32'(bus.grant), 32'b0001);
    repeat (3) @(negedge clk);
    bus.req = '0;
    @(negedge clk); #1;
    check("single_grant_drop", 32'(bus.grant), 0);
    check("single_unlock_data", bus.m_writedata, 32'h0100_0000);
    @(negedge clk); #1;
    check("single_busy_off", 32'(bus.busy), 0);

    // Contention with software holding the mutex, then release.
    sw_write(32'h0001_0001);
    wr_q.push_back(32'h0102_0001); wr_q.push_back(32'h0102_0001); wr_q.push_back(32'h0102_0000);
    gnt_q.push_back(4'b0100);      gnt_q.push_back(4'b0000);
    bus.req = 4'b0100;
    wait_queue(2, 10);
    repeat (3) @(negedge clk);
    check("cont_fail_cnt", 32'(bus.fail_cnt), 1);
    check("cont_busy_backoff", 32'(bus.busy), 1);
    sw_write(32'h0000_0000);
    wait_grant("cont_grant_wait", 40);
    check("cont_retry_gap", wr_gap, 3 + RETRY_DELAY);
    check("cont_grant", 32'(bus.grant), 32'b0100);
    check("cont_fail_cnt_kept", 32'(bus.fail_cnt), 1);
    bus.req = '0;
    wait_queue(0, 20);

    // Round robin with all requesters active.
    pulse_reset();
    for (int k = 0; k < 5; k++) begin
      wr_q.push_back({16'h0100 + 16'(k % 4), 16'h0001});
      wr_q.push_back({16'h0100 + 16'(k % 4), 16'h0000});
      gnt_q.push_back(4'(1 << (k % 4)));
      gnt_q.push_back(4'b0000);
    end
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant("rr_grant_wait", 30);
      if (k > 0) check("rr_unlock_to_grant", grant_rise_cyc - unlock_cyc, 4);
      repeat (5) @(negedge clk);
      bus.req = (k == 4) ? '0 : (bus.req & ~bus.grant);
      @(negedge clk);
      if (k < 4) bus.req = 4'b1111;
    end
    wait_queue(0, 20);

    // Withdrawal during RD_CHECK: no grant, unlock follows at once.
    wr_q.push_back(32'h0102_0001); wr_q.push_back(32'h0102_0000);
    @(negedge clk);
    bus.req = 4'b0100;
    repeat (2) @(negedge clk);
    bus.req = '0;
    @(negedge clk); #1;
    check("wd_unlock_data", bus.m_writedata, 32'h0102_0000);
    check("wd_unlock_gap", wr_gap, 2);
    check("wd_no_grant", 32'(bus.grant), 0);
    repeat (2) @(negedge clk);

    // Reset while requester 1 holds the lock.
    wr_q.push_back(32'h0101_0001);
    gnt_q.push_back(4'b0010); gnt_q.push_back(4'b0000);
    bus.req = 4'b0010;
    wait_grant("rst_grant_wait", 20);
    check("rst_pre_grant", 32'(bus.grant), 32'b0010);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({bus.grant, bus.busy, bus.fail_cnt,
                                 bus.m_chipselect, bus.m_write, bus.m_read}), 0);
    bus.req = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Mutex still owned by 0x0101: requester 0 fails on every attempt.
    bus.req = 4'b0001;
    for (int k = 1; k <= 3; k++) begin
      wr_q.push_back(32'h0100_0001);
      wait_queue(0, 30);
      repeat (3) @(negedge clk);
      check("held_fail_cnt", 32'(bus.fail_cnt), 32'(k));
    end
    bus.req = '0;
    repeat (10) @(negedge clk);

    // Same owner as before the reset takes the lock again.
    wr_q.push_back(32'h0101_0001); wr_q.push_back(32'h0101_0000);
    gnt_q.push_back(4'b0010);      gnt_q.push_back(4'b0000);
    bus.req = 4'b0010;
    wait_grant("owner_grant_wait", 30);
    check("owner_match_grant", 32'(bus.grant), 32'b0010);
    check("owner_match_fail_cnt", 32'(bus.fail_cnt), 3);
    bus.req = '0;
    wait_queue(0, 20);

    // Saturation of the failure counter.
    sw_write(32'h0001_0001);
    force dut.fail_cnt_q = 16'hFFFD;
    @(negedge clk);
    release dut.fail_cnt_q;
    #1;
    check("sat_preload", 32'(bus.fail_cnt), 32'hFFFD);
    bus.req = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      wr_q.push_back(32'h0102_0001);
      wait_queue(0, 30);
      repeat (3) @(negedge clk);
      check("sat_fail_cnt", 32'(bus.fail_cnt), (32'hFFFD + k > 32'hFFFF) ? 32'hFFFF : 32'hFFFD + k);
    end
    bus.req = '0;
    repeat (14) @(negedge clk); #1;
    check("final_busy", 32'(bus.busy), 0);
    check("final_wr_q_empty", wr_q.size(), 0);
    check("final_gnt_q_empty", gnt_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
